fifo_sync_buffer: RTL and testbench

Single-clock, parametrised synchronous FIFO for buffering QAM symbol words between same-clock pipeline stages of the modulator datapath. It replaces the fixed 10-bit, 4-deep FIFO storage with configurable width and depth, and adds an occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags, and a selectable first-word-fall-through (FWFT) read mode. Full/empty are derived internally, so upstream and downstream stages only drive enables.

---
 rtl/fifo_pkg.sv | 22 ++
 rtl/fifo_sync_ram.sv | 29 ++
 rtl/fifo_sync_buffer.sv | 124 ++++++++++++
 tb/tb_fifo_sync_buffer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO family.
// Provides pointer/count width and elaboration-time parameter legality.
// No logic; pure compile-time definitions.
package fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 10;
  localparam int DEFAULT_DEPTH      = 16;

  // Pointers and count carry one extra bit so that a full FIFO (count == DEPTH)
  // is representable and the pointer MSB acts as the wrap bit.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // DEPTH must be a power of two (pointers wrap naturally) and the
  // thresholds must be strictly ordered inside the occupancy range.
  function automatic bit params_legal(input int depth, input int ae_level, input int af_level);
    return (depth >= 2) && ((depth & (depth - 1)) == 0) &&
           (ae_level > 0) && (ae_level < af_level) && (af_level <= depth);
  endfunction

endpackage

// File: rtl/fifo_sync_ram.sv
// Register-array storage for the FIFO: one synchronous write port, one asynchronous read port.
// Latency: write visible on the read port after the write edge; read is combinational.
// No flow control here; the parent decides when a write is accepted.
module fifo_sync_ram
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]    rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Storage is deliberately not reset; the parent's pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_sync_buffer.sv
// Parametrised single-clock FIFO with occupancy count, threshold flags and sticky error flags.
// Latency: FWFT=0 -> data one cycle after accepted read; FWFT=1 -> head word shown combinationally.
// Backpressure: writes when full are dropped (overflow), reads when empty are ignored (underflow).
module fifo_sync_buffer
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH         = DEFAULT_DATA_WIDTH,
  parameter int DEPTH              = DEFAULT_DEPTH,
  parameter int ALMOST_FULL_LEVEL  = DEPTH - 2,
  parameter int ALMOST_EMPTY_LEVEL = 2,
  parameter bit FWFT               = 1'b0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       write_enable,
  input  logic [DATA_WIDTH-1:0]      data_in,
  input  logic                       read_enable,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic                       data_valid,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow,
  input  logic                       clear_errors
);

  localparam int CW = ptr_width(DEPTH);
  localparam int AW = CW - 1;

  if (!params_legal(DEPTH, ALMOST_EMPTY_LEVEL, ALMOST_FULL_LEVEL)) begin : g_illegal_params
    $error("fifo_sync_buffer: illegal DEPTH or almost-full/almost-empty levels");
  end

  logic [CW-1:0]         write_pointer;
  logic [CW-1:0]         read_pointer;
  logic                  read_accept;
  logic                  write_accept;
  logic [DATA_WIDTH-1:0] rd_data;

  // A read frees a slot in the same cycle, so a full FIFO can still take a write.
  assign read_accept  = read_enable && !empty;
  assign write_accept = write_enable && (!full || read_accept);

  // Flags depend only on the registered count: no enable-to-flag path.
  assign full         = (count == CW'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= CW'(ALMOST_FULL_LEVEL));
  assign almost_empty = (count <= CW'(ALMOST_EMPTY_LEVEL));

  fifo_sync_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (write_accept),
    .wr_addr (write_pointer[AW-1:0]),
    .wr_data (data_in),
    .rd_addr (read_pointer[AW-1:0]),
    .rd_data (rd_data)
  );

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      write_pointer <= '0;
      read_pointer  <= '0;
      count         <= '0;
    end else begin
      if (write_accept) write_pointer <= write_pointer + CW'(1);
      if (read_accept)  read_pointer  <= read_pointer + CW'(1);
      case ({write_accept, read_accept})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags; clearing wins over a same-cycle error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clear_errors) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (write_enable && !write_accept) overflow  <= 1'b1;
      if (read_enable && empty)          underflow <= 1'b1;
    end
  end

  // The wrap-bit pointer difference must always agree with the tracked count.
  a_count_matches_pointers: assert property (
    @(posedge clk) disable iff (!reset_n) count == (write_pointer - read_pointer)
  );

  if (FWFT) begin : g_fwft
    // Head word is presented directly; read_enable acknowledges it.
    assign data_out   = rd_data;
    assign data_valid = !empty;
  end else begin : g_registered
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;

    // Capture the head word on an accepted read; valid pulses for one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= read_accept;
        if (read_accept) data_q <= rd_data;
      end
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
  end

endmodule

// File: tb/tb_fifo_sync_buffer.sv
// Bench for fifo_sync_buffer: registered and FWFT instances share one stimulus stream.
// A queue-based model is compared against both on every falling edge.
// Directed steps add hand-computed literal expectations.
module tb_fifo_sync_buffer;

  localparam int DW    = 10;
  localparam int DEPTH = 16;
  localparam int AFL   = DEPTH - 2;
  localparam int AEL   = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          we = 1'b0;
  logic          re = 1'b0;
  logic          clr = 1'b0;
  logic [DW-1:0] din = '0;

  logic [DW-1:0] dout0, dout1;
  logic          dval0, dval1, full0, full1, empty0, empty1;
  logic          af0, af1, ae0, ae1, ovf0, ovf1, unf0, unf1;
  logic [4:0]    cnt0, cnt1;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Behavioural model state
  int      q[$];
  int      m_dout = 0;
  bit      m_dval = 1'b0;
  bit      m_ovf  = 1'b0;
  bit      m_unf  = 1'b0;

  always #5 clk = ~clk;

  fifo_sync_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ALMOST_FULL_LEVEL(AFL),
                     .ALMOST_EMPTY_LEVEL(AEL), .FWFT(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n), .write_enable(we), .data_in(din), .read_enable(re),
    .data_out(dout0), .data_valid(dval0), .full(full0), .empty(empty0),
    .almost_full(af0), .almost_empty(ae0), .count(cnt0), .overflow(ovf0),
    .underflow(unf0), .clear_errors(clr));

  fifo_sync_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ALMOST_FULL_LEVEL(AFL),
                     .ALMOST_EMPTY_LEVEL(AEL), .FWFT(1'b1)) dut1 (
    .clk(clk), .reset_n(reset_n), .write_enable(we), .data_in(din), .read_enable(re),
    .data_out(dout1), .data_valid(dval1), .full(full1), .empty(empty1),
    .almost_full(af1), .almost_empty(ae1), .count(cnt1), .overflow(ovf1),
    .underflow(unf1), .clear_errors(clr));

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: FIFO semantics expressed on a queue.
  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        q.delete();
        m_dout = 0; m_dval = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
      end else begin
        automatic int  sz    = q.size();
        automatic bit  rd_ok = re && (sz > 0);
        automatic bit  wr_ok = we && ((sz < DEPTH) || rd_ok);
        if (rd_ok) m_dout = q.pop_front();
        m_dval = rd_ok;
        if (wr_ok) q.push_back(int'(din));
        if (clr) begin
          m_ovf = 1'b0; m_unf = 1'b0;
        end else begin
          if (we && !wr_ok) m_ovf = 1'b1;
          if (re && sz == 0) m_unf = 1'b1;
        end
      end
    end
  end

  // Compare both DUTs against the model away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        automatic int sz = q.size();
        chk("count0", int'(cnt0), sz);
        chk("count1", int'(cnt1), sz);
        chk("empty0", int'(empty0), int'(sz == 0));
        chk("empty1", int'(empty1), int'(sz == 0));
        chk("full0", int'(full0), int'(sz == DEPTH));
        chk("full1", int'(full1), int'(sz == DEPTH));
        chk("afull0", int'(af0), int'(sz >= AFL));
        chk("afull1", int'(af1), int'(sz >= AFL));
        chk("aempty0", int'(ae0), int'(sz <= AEL));
        chk("aempty1", int'(ae1), int'(sz <= AEL));
        chk("ovf0", int'(ovf0), int'(m_ovf));
        chk("ovf1", int'(ovf1), int'(m_ovf));
        chk("unf0", int'(unf0), int'(m_unf));
        chk("unf1", int'(unf1), int'(m_unf));
        chk("dval0", int'(dval0), int'(m_dval));
        chk("dout0", int'(dout0), m_dout);
        chk("dval1", int'(dval1), int'(sz > 0));
        if (sz > 0) chk("dout1", int'(dout1), q[0]);
      end
    end
  end

  // One operation cycle: drive, take the edge, return 1 time unit later with inputs idle.
  task automatic cyc(input bit w, input int d, input bit r, input bit c);
    we = w; din = DW'(d); re = r; clr = c;
    @(posedge clk);
    #1;
    we = 1'b0; re = 1'b0; clr = 1'b0; din = '0;
  endtask

  initial begin
    int pushed, popped, occ, guard;
    #1 reset_n = 1'b0;
    #1 chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Reset then idle
    cyc(0, 0, 0, 0);
    chk("rst_count", int'(cnt0), 0);
    chk("rst_empty", int'(empty0), 1);
    chk("rst_aempty", int'(ae0), 1);
    chk("rst_full", int'(full0), 0);
    chk("rst_dval", int'(dval0), 0);
    chk("rst_dout", int'(dout0), 0);

    // Fill 0x001..0x010
    for (int i = 1; i <= DEPTH; i++) begin
      cyc(1, i, 0, 0);
      if (i == 13) chk("af_at13", int'(af0), 0);
      if (i == 14) chk("af_at14", int'(af0), 1);
    end
    chk("fill_full", int'(full0), 1);
    chk("fill_count", int'(cnt0), 16);

    // Overflow while full, then clear
    cyc(1, 'h3FF, 0, 0);
    chk("ovf_set", int'(ovf0), 1);
    chk("ovf_count", int'(cnt0), 16);
    cyc(0, 0, 0, 1);
    chk("ovf_clear", int'(ovf0), 0);

    // Drain in order
    for (int i = 1; i <= DEPTH; i++) begin
      cyc(0, 0, 1, 0);
      chk("drain_dout", int'(dout0), i);
      chk("drain_dval", int'(dval0), 1);
      if (i == 1) chk("full_drop", int'(full0), 0);
    end
    chk("drain_empty", int'(empty0), 1);
    cyc(0, 0, 0, 0);
    chk("dval_pulse", int'(dval0), 0);
    chk("dout_hold", int'(dout0), 16);

    // Empty with both enables
    cyc(1, 'h155, 1, 0);
    chk("unf_set", int'(unf0), 1);
    chk("unf_count", int'(cnt0), 1);
    chk("unf_fwft_dout", int'(dout1), 'h155);
    cyc(0, 0, 1, 0);
    chk("unf_read", int'(dout0), 'h155);
    cyc(0, 0, 0, 1);
    chk("unf_clear", int'(unf0), 0);

    // FWFT visibility and acknowledge
    cyc(1, 'h2AA, 0, 0);
    chk("fwft_dout", int'(dout1), 'h2AA);
    chk("fwft_dval", int'(dval1), 1);
    cyc(0, 0, 1, 0);
    chk("fwft_empty", int'(empty1), 1);
    chk("fwft_reg_dout", int'(dout0), 'h2AA);

    // Random interleaving, never exceeding depth
    pushed = 0; popped = 0; occ = 0; guard = 0;
    while ((pushed < 40 || popped < pushed) && guard < 1000) begin
      automatic bit w = (pushed < 40) && (occ < DEPTH) && ($urandom_range(0, 1) == 1);
      automatic bit r = (occ > 0) && ($urandom_range(0, 1) == 1);
      cyc(w, w ? ('h100 + pushed) : 0, r, 0);
      if (w) begin pushed++; occ++; end
      if (r) begin popped++; occ--; end
      guard++;
    end
    chk("wrap_done", int'(popped), 40);
    chk("wrap_ovf", int'(ovf0), 0);
    chk("wrap_unf", int'(unf0), 0);

    // Full with both enables
    for (int i = 1; i <= DEPTH; i++) cyc(1, 'h40 + i, 0, 0);
    cyc(1, 'h0AB, 1, 0);
    chk("both_count", int'(cnt0), 16);
    chk("both_full", int'(full0), 1);
    chk("both_first", int'(dout0), 'h41);
    for (int i = 2; i <= DEPTH; i++) cyc(0, 0, 1, 0);
    chk("both_last_orig", int'(dout0), 'h50);
    cyc(0, 0, 1, 0);
    chk("both_ab", int'(dout0), 'h0AB);
    chk("both_empty", int'(empty0), 1);

    // Mid-stream asynchronous reset
    cyc(0, 0, 1, 0);
    for (int i = 0; i < 3; i++) cyc(1, 'h30 + i, 0, 0);
    cyc(0, 0, 1, 0);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("ar_count", int'(cnt0), 0);
    chk("ar_empty", int'(empty0), 1);
    chk("ar_aempty", int'(ae0), 1);
    chk("ar_full", int'(full0), 0);
    chk("ar_unf", int'(unf0), 0);
    chk("ar_dval0", int'(dval0), 0);
    chk("ar_dout0", int'(dout0), 0);
    chk("ar_dval1", int'(dval1), 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    cyc(1, 'h077, 0, 0);
    cyc(0, 0, 1, 0);
    chk("post_rst_read", int'(dout0), 'h077);
    cyc(0, 0, 0, 0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
